// File: rtl/fwd_hazard_unit.sv
// Forwarding and hazard controller for the 5-stage pipeline: EX operand bypass,
// ID-stage ecall bypass, load-use/ecall interlock FSM and a saturating stall counter.
module fwd_hazard_unit #(
  parameter int NUM_SRC    = 2,
  parameter int XLEN       = 32,
  parameter int LU_BUBBLES = 1,
  parameter int ECALL_REG  = 17
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    hold,
  input  logic                    id_valid,
  input  logic [NUM_SRC*5-1:0]    id_rs,
  input  logic [NUM_SRC-1:0]      id_rs_used,
  input  logic                    id_is_ecall,
  input  logic [XLEN-1:0]         id_ecall_rf_data,
  input  logic [NUM_SRC*5-1:0]    ex_rs,
  input  logic [NUM_SRC*XLEN-1:0] ex_rf_data,
  input  logic [4:0]              ex_rd,
  input  logic                    ex_reg_write,
  input  logic                    ex_mem_read,
  input  logic [4:0]              mem_rd,
  input  logic                    mem_reg_write,
  input  logic [XLEN-1:0]         mem_data,
  input  logic [4:0]              wb_rd,
  input  logic                    wb_reg_write,
  input  logic [XLEN-1:0]         wb_data,
  output logic [NUM_SRC*2-1:0]    fwd_sel,
  output logic [NUM_SRC*XLEN-1:0] ex_op_data,
  output logic [1:0]              ecall_sel,
  output logic [XLEN-1:0]         ecall_data,
  output logic                    stall,
  output logic                    id_ex_flush,
  output logic [31:0]             stall_cycles
);

  localparam logic [4:0] ECALL_RD = 5'(ECALL_REG);
  localparam logic [2:0] CNT_INIT = 3'(LU_BUBBLES - 1);

  typedef enum logic {
    S_IDLE,
    S_BUBBLE
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [2:0]  r_cnt;
  logic [2:0]  w_next_cnt;
  logic [31:0] r_stall_cycles;

  logic [NUM_SRC-1:0] w_lu_slot;
  logic               w_lu_hit;
  logic               w_ecall_hit;
  logic               w_hz;

  // Per-slot EX bypass; the MEM stage holds the younger result so it takes priority.
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_slot
    logic [4:0] w_rs;
    logic       w_mem_hit;
    logic       w_wb_hit;
    assign w_rs      = ex_rs[5*i +: 5];
    assign w_mem_hit = mem_reg_write && (mem_rd != 5'd0) && (mem_rd == w_rs);
    assign w_wb_hit  = wb_reg_write && (wb_rd != 5'd0) && (wb_rd == w_rs);

    always_comb begin
      fwd_sel[2*i +: 2]           = 2'b00;
      ex_op_data[XLEN*i +: XLEN]  = ex_rf_data[XLEN*i +: XLEN];
      if (w_mem_hit) begin
        fwd_sel[2*i +: 2]          = 2'b01;
        ex_op_data[XLEN*i +: XLEN] = mem_data;
      end else if (w_wb_hit) begin
        fwd_sel[2*i +: 2]          = 2'b10;
        ex_op_data[XLEN*i +: XLEN] = wb_data;
      end
    end

    assign w_lu_slot[i] = id_rs_used[i] && (id_rs[5*i +: 5] == ex_rd);
  end

  always_comb begin
    ecall_sel  = 2'b00;
    ecall_data = id_ecall_rf_data;
    if (id_is_ecall) begin
      if (mem_reg_write && (mem_rd == ECALL_RD)) begin
        ecall_sel  = 2'b01;
        ecall_data = mem_data;
      end else if (wb_reg_write && (wb_rd == ECALL_RD)) begin
        ecall_sel  = 2'b10;
        ecall_data = wb_data;
      end
    end
  end

  assign w_lu_hit    = ex_mem_read && (|w_lu_slot);
  assign w_ecall_hit = id_is_ecall && (ex_rd == ECALL_RD);
  assign w_hz        = id_valid && ex_reg_write && (ex_rd != 5'd0) && (w_lu_hit || w_ecall_hit);

  // The first bubble is issued from IDLE, so BUBBLE only covers the remaining ones.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    stall        = 1'b0;
    case (r_state)
      S_IDLE: begin
        stall = w_hz;
        if (w_hz && !hold && (LU_BUBBLES > 1)) begin
          w_next_state = S_BUBBLE;
          w_next_cnt   = CNT_INIT;
        end
      end
      S_BUBBLE: begin
        stall = 1'b1;
        if (!hold) begin
          if (r_cnt <= 3'd1) begin
            w_next_state = S_IDLE;
            w_next_cnt   = 3'd0;
          end else begin
            w_next_cnt = r_cnt - 3'd1;
          end
        end
      end
      default: begin
        w_next_state = S_IDLE;
        w_next_cnt   = 3'd0;
      end
    endcase
  end

  assign id_ex_flush = stall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cycles <= 32'd0;
    end else if (stall && (r_stall_cycles != 32'hFFFF_FFFF)) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit; dut3 runs with 3 bubbles, dut1 with 1,
// both sharing the same stimulus.
module tb_fwd_hazard_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        hold;
  logic        idValid;
  logic [9:0]  idRs;
  logic [1:0]  idRsUsed;
  logic        idIsEcall;
  logic [31:0] idEcallRfData;
  logic [9:0]  exRs;
  logic [63:0] exRfData;
  logic [4:0]  exRd;
  logic        exRegWrite;
  logic        exMemRead;
  logic [4:0]  memRd;
  logic        memRegWrite;
  logic [31:0] memData;
  logic [4:0]  wbRd;
  logic        wbRegWrite;
  logic [31:0] wbData;

  logic [3:0]  fwdSel3, fwdSel1;
  logic [63:0] exOpData3, exOpData1;
  logic [1:0]  ecallSel3, ecallSel1;
  logic [31:0] ecallData3, ecallData1;
  logic        stall3, stall1, flush3, flush1;
  logic [31:0] stallCycles3, stallCycles1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fwd_hazard_unit #(.NUM_SRC(2), .XLEN(32), .LU_BUBBLES(3), .ECALL_REG(17)) dut3 (
    .clk(clk), .reset(reset), .hold(hold), .id_valid(idValid), .id_rs(idRs),
    .id_rs_used(idRsUsed), .id_is_ecall(idIsEcall), .id_ecall_rf_data(idEcallRfData),
    .ex_rs(exRs), .ex_rf_data(exRfData), .ex_rd(exRd), .ex_reg_write(exRegWrite),
    .ex_mem_read(exMemRead), .mem_rd(memRd), .mem_reg_write(memRegWrite),
    .mem_data(memData), .wb_rd(wbRd), .wb_reg_write(wbRegWrite), .wb_data(wbData),
    .fwd_sel(fwdSel3), .ex_op_data(exOpData3), .ecall_sel(ecallSel3),
    .ecall_data(ecallData3), .stall(stall3), .id_ex_flush(flush3),
    .stall_cycles(stallCycles3)
  );

  fwd_hazard_unit #(.NUM_SRC(2), .XLEN(32), .LU_BUBBLES(1), .ECALL_REG(17)) dut1 (
    .clk(clk), .reset(reset), .hold(hold), .id_valid(idValid), .id_rs(idRs),
    .id_rs_used(idRsUsed), .id_is_ecall(idIsEcall), .id_ecall_rf_data(idEcallRfData),
    .ex_rs(exRs), .ex_rf_data(exRfData), .ex_rd(exRd), .ex_reg_write(exRegWrite),
    .ex_mem_read(exMemRead), .mem_rd(memRd), .mem_reg_write(memRegWrite),
    .mem_data(memData), .wb_rd(wbRd), .wb_reg_write(wbRegWrite), .wb_data(wbData),
    .fwd_sel(fwdSel1), .ex_op_data(exOpData1), .ecall_sel(ecallSel1),
    .ecall_data(ecallData1), .stall(stall1), .id_ex_flush(flush1),
    .stall_cycles(stallCycles1)
  );

  task automatic clearInputs();
    hold          = 1'b0;
    idValid       = 1'b0;
    idRs          = '0;
    idRsUsed      = '0;
    idIsEcall     = 1'b0;
    idEcallRfData = 32'hEC00_0017;
    exRs          = '0;
    exRfData      = {32'h2222_0000, 32'h1111_0000};
    exRd          = '0;
    exRegWrite    = 1'b0;
    exMemRead     = 1'b0;
    memRd         = '0;
    memRegWrite   = 1'b0;
    memData       = '0;
    wbRd          = '0;
    wbRegWrite    = 1'b0;
    wbData        = '0;
  endtask

  task automatic pulseReset();
    @(negedge clk);
    reset = 1'b0;
    clearInputs();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    clearInputs();
    #1;
    checks++;
    if (stall3 !== 1'b0 || flush3 !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_stall got=%0b/%0b exp=0/0", stall3, flush3);
    end
    checks++;
    if (fwdSel3 !== 4'b0000 || ecallSel3 !== 2'b00) begin
      failures++;
      $display("[TB] FAIL reset_sel got=%b/%b exp=0000/00", fwdSel3, ecallSel3);
    end
    checks++;
    if (exOpData3 !== 64'h2222_0000_1111_0000 || ecallData3 !== 32'hEC00_0017) begin
      failures++;
      $display("[TB] FAIL reset_data got=%h/%h exp=2222000011110000/ec000017", exOpData3, ecallData3);
    end
    checks++;
    if (stallCycles3 !== 32'd0 || stallCycles1 !== 32'd0) begin
      failures++;
      $display("[TB] FAIL reset_cnt got=%0d/%0d exp=0/0", stallCycles3, stallCycles1);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_ex_forward();
    @(negedge clk);
    clearInputs();
    exRs        = {5'd7, 5'd5};
    memRd       = 5'd5;
    memRegWrite = 1'b1;
    memData     = 32'h0000_1234;
    #1;
    checks++;
    if (fwdSel3 !== 4'b0001 || exOpData3 !== 64'h2222_0000_0000_1234) begin
      failures++;
      $display("[TB] FAIL fwd_mem got=%b/%h exp=0001/2222000000001234", fwdSel3, exOpData3);
    end
    memData    = 32'h0000_AAAA;
    wbRd       = 5'd5;
    wbRegWrite = 1'b1;
    wbData     = 32'h0000_BBBB;
    #1;
    checks++;
    if (fwdSel3 !== 4'b0001 || exOpData3 !== 64'h2222_0000_0000_AAAA) begin
      failures++;
      $display("[TB] FAIL fwd_mem_prio got=%b/%h exp=0001/222200000000aaaa", fwdSel3, exOpData3);
    end
    memRegWrite = 1'b0;
    exRs        = {5'd5, 5'd9};
    #1;
    checks++;
    if (fwdSel3 !== 4'b1000 || exOpData3 !== 64'h0000_BBBB_1111_0000) begin
      failures++;
      $display("[TB] FAIL fwd_wb got=%b/%h exp=1000/0000bbbb11110000", fwdSel3, exOpData3);
    end
    exRs        = {5'd0, 5'd0};
    memRd       = 5'd0;
    memRegWrite = 1'b1;
    wbRd        = 5'd0;
    #1;
    checks++;
    if (fwdSel3 !== 4'b0000 || exOpData3 !== 64'h2222_0000_1111_0000) begin
      failures++;
      $display("[TB] FAIL fwd_x0 got=%b/%h exp=0000/2222000011110000", fwdSel3, exOpData3);
    end
  endtask

  task automatic test_load_use_1();
    pulseReset();
    @(negedge clk);
    idValid    = 1'b1;
    idRs       = {5'd6, 5'd2};
    idRsUsed   = 2'b01;
    exRd       = 5'd6;
    exRegWrite = 1'b1;
    exMemRead  = 1'b1;
    #1;
    checks++;
    if (stall1 !== 1'b0 || stall3 !== 1'b0) begin
      failures++;
      $display("[TB] FAIL lu_unused_slot got=%0b/%0b exp=0/0", stall1, stall3);
    end
    idRsUsed = 2'b10;
    #1;
    checks++;
    if (stall1 !== 1'b1 || flush1 !== 1'b1) begin
      failures++;
      $display("[TB] FAIL lu1_stall got=%0b/%0b exp=1/1", stall1, flush1);
    end
    @(negedge clk);
    exRd        = 5'd0;
    exRegWrite  = 1'b0;
    exMemRead   = 1'b0;
    memRd       = 5'd6;
    memRegWrite = 1'b1;
    #1;
    checks++;
    if (stall1 !== 1'b0 || flush1 !== 1'b0) begin
      failures++;
      $display("[TB] FAIL lu1_release got=%0b/%0b exp=0/0", stall1, flush1);
    end
    @(negedge clk);
    idValid     = 1'b0;
    exRs        = {5'd6, 5'd2};
    memRd       = 5'd0;
    memRegWrite = 1'b0;
    wbRd        = 5'd6;
    wbRegWrite  = 1'b1;
    wbData      = 32'h0000_5555;
    #1;
    checks++;
    if (fwdSel1 !== 4'b1000 || exOpData1 !== 64'h0000_5555_1111_0000) begin
      failures++;
      $display("[TB] FAIL lu1_wb_fwd got=%b/%h exp=1000/0000555511110000", fwdSel1, exOpData1);
    end
    checks++;
    if (stallCycles1 !== 32'd1) begin
      failures++;
      $display("[TB] FAIL lu1_cnt got=%0d exp=1", stallCycles1);
    end
  endtask

  task automatic test_load_use_hold();
    logic expStall [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic holdSeq  [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    pulseReset();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      hold = holdSeq[c];
      if (c == 0) begin
        idValid    = 1'b1;
        idRs       = {5'd6, 5'd2};
        idRsUsed   = 2'b10;
        exRd       = 5'd6;
        exRegWrite = 1'b1;
        exMemRead  = 1'b1;
      end else begin
        exRd       = 5'd0;
        exRegWrite = 1'b0;
        exMemRead  = 1'b0;
      end
      #1;
      checks++;
      if (stall3 !== expStall[c] || flush3 !== expStall[c]) begin
        failures++;
        $display("[TB] FAIL lu3_hold_stall cycle=%0d got=%0b/%0b exp=%0b", c, stall3, flush3, expStall[c]);
      end
    end
    checks++;
    if (stallCycles3 !== 32'd5) begin
      failures++;
      $display("[TB] FAIL lu3_hold_cnt got=%0d exp=5", stallCycles3);
    end
  endtask

  task automatic test_ecall();
    pulseReset();
    @(negedge clk);
    idValid    = 1'b1;
    idIsEcall  = 1'b1;
    exRd       = 5'd17;
    exRegWrite = 1'b1;
    #1;
    checks++;
    if (stall1 !== 1'b1 || flush1 !== 1'b1 || ecallSel1 !== 2'b00 || ecallData1 !== 32'hEC00_0017) begin
      failures++;
      $display("[TB] FAIL ecall_stall got=%0b/%0b/%b/%h exp=1/1/00/ec000017", stall1, flush1, ecallSel1, ecallData1);
    end
    @(negedge clk);
    exRd        = 5'd0;
    exRegWrite  = 1'b0;
    memRd       = 5'd17;
    memRegWrite = 1'b1;
    memData     = 32'h0000_0077;
    #1;
    checks++;
    if (stall1 !== 1'b0 || ecallSel1 !== 2'b01 || ecallData1 !== 32'h0000_0077) begin
      failures++;
      $display("[TB] FAIL ecall_mem got=%0b/%b/%h exp=0/01/00000077", stall1, ecallSel1, ecallData1);
    end
    @(negedge clk);
    memRd       = 5'd0;
    memRegWrite = 1'b0;
    wbRd        = 5'd17;
    wbRegWrite  = 1'b1;
    wbData      = 32'h0000_0099;
    #1;
    checks++;
    if (ecallSel1 !== 2'b10 || ecallData1 !== 32'h0000_0099) begin
      failures++;
      $display("[TB] FAIL ecall_wb got=%b/%h exp=10/00000099", ecallSel1, ecallData1);
    end
    idIsEcall = 1'b0;
    #1;
    checks++;
    if (ecallSel1 !== 2'b00 || ecallData1 !== 32'hEC00_0017) begin
      failures++;
      $display("[TB] FAIL ecall_off got=%b/%h exp=00/ec000017", ecallSel1, ecallData1);
    end
  endtask

  task automatic test_reset_mid_bubble();
    pulseReset();
    @(negedge clk);
    idValid    = 1'b1;
    idRs       = {5'd6, 5'd2};
    idRsUsed   = 2'b10;
    exRd       = 5'd6;
    exRegWrite = 1'b1;
    exMemRead  = 1'b1;
    @(negedge clk);
    exRd       = 5'd0;
    exRegWrite = 1'b0;
    exMemRead  = 1'b0;
    #1;
    checks++;
    if (stall3 !== 1'b1) begin
      failures++;
      $display("[TB] FAIL bubble_before_reset got=%0b exp=1", stall3);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (stall3 !== 1'b0 || flush3 !== 1'b0 || stallCycles3 !== 32'd0) begin
      failures++;
      $display("[TB] FAIL mid_bubble_reset got=%0b/%0b/%0d exp=0/0/0", stall3, flush3, stallCycles3);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c == 0) begin
        exRd       = 5'd6;
        exRegWrite = 1'b1;
        exMemRead  = 1'b1;
      end else begin
        exRd       = 5'd0;
        exRegWrite = 1'b0;
        exMemRead  = 1'b0;
      end
      #1;
      checks++;
      if (stall3 !== (c < 3)) begin
        failures++;
        $display("[TB] FAIL post_reset_stall cycle=%0d got=%0b exp=%0b", c, stall3, (c < 3));
      end
    end
    checks++;
    if (stallCycles3 !== 32'd3) begin
      failures++;
      $display("[TB] FAIL post_reset_cnt got=%0d exp=3", stallCycles3);
    end
  endtask

  initial begin
    test_reset();
    test_ex_forward();
    test_load_use_1();
    test_load_use_hold();
    test_ecall();
    test_reset_mid_bubble();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
